// File: rtl/r4u1_coef_wr.sv
// Radix-4 unit-1 twiddle coefficient table with a streaming write port.
// A producer loads DEPTH coefficient words ({real, imag}) through a
// valid/ready handshake after a load_start pulse; the table is then read
// through a one-cycle registered port that matches the unit-1 twiddle ROM.
module r4u1_coef_wr #(
    parameter int CW    = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2*CW-1:0] wr_data,
    output logic            load_done,
    output logic            load_err,
    input  logic [2:0]      rd_addr,
    output logic [2*CW-1:0] rd_data,
    output logic            rd_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Index of the final table entry; a transfer here completes the load.
    localparam logic [2:0] LAST_IDX = 3'(DEPTH - 1);

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [2:0]      wr_cnt_reg;
    logic [2:0]      wr_cnt_next;
    logic            wr_ready_reg;
    logic            load_done_reg;
    logic            load_err_reg;
    logic            load_err_next;
    logic [2*CW-1:0] rd_data_reg;
    logic            rd_valid_reg;

    logic            xfer;
    logic            wr_en;
    logic [2:0]      wr_addr;

    // Table storage: no reset so it maps onto block RAM.
    logic [2*CW-1:0] mem [DEPTH];

    // A word moves only when the producer offers it and we are loading.
    assign xfer = wr_valid & wr_ready_reg;

    // Next-state, write-address and error-flag decode.
    always_comb begin
        state_next    = state_reg;
        wr_cnt_next   = wr_cnt_reg;
        load_err_next = load_err_reg;
        wr_en         = 1'b0;
        wr_addr       = wr_cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                // A fresh load clears the error history of the previous one.
                if (load_start) begin
                    state_next    = LOAD;
                    wr_cnt_next   = 3'd0;
                    load_err_next = 1'b0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    // Restart mid-load: a word arriving on the restart
                    // cycle belongs to the new load and lands in entry 0.
                    load_err_next = 1'b1;
                    if (xfer) begin
                        wr_en       = 1'b1;
                        wr_addr     = 3'd0;
                        wr_cnt_next = 3'd1;
                    end else begin
                        wr_cnt_next = 3'd0;
                    end
                end else if (xfer) begin
                    wr_en = 1'b1;
                    if (wr_cnt_reg == LAST_IDX) begin
                        // Exit instead of wrapping so a full table is
                        // never overwritten by a runaway producer.
                        state_next  = DONE;
                        wr_cnt_next = 3'd0;
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                wr_cnt_next = 3'd0;
            end
        endcase
    end

    // Control registers; wr_ready and load_done are decoded from the
    // next state so they are clean flop outputs aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_cnt_reg    <= 3'd0;
            wr_ready_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            wr_ready_reg  <= (state_next == LOAD);
            load_done_reg <= (state_next == DONE);
            load_err_reg  <= load_err_next;
        end
    end

    // Table write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read in every state; a same-entry write in the same cycle
    // returns the old contents. rd_valid trails load_done by one cycle so it
    // lines up with the data it qualifies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_data_reg  <= mem[rd_addr];
            rd_valid_reg <= load_done_reg;
        end
    end

    assign wr_ready  = wr_ready_reg;
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

endmodule

// File: tb/tb_r4u1_coef_wr.sv
// Self-checking bench for r4u1_coef_wr: a table of hand-written vectors for
// the basic load, hand sequences for restart/reset corners, and a read
// scoreboard fed by a small behavioural model of the loader.
module tb_r4u1_coef_wr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        load_done;
    logic        load_err;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    always #5 clk = ~clk;

    r4u1_coef_wr #(.CW(16), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .load_done  (load_done),
        .load_err   (load_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (0 idle, 1 load, 2 done).
    int          m_state;
    logic [2:0]  m_cnt;
    bit          m_done;
    bit          m_err;
    logic [31:0] m_mem [8];
    bit          m_known [8];

    typedef struct {
        logic [31:0] data;
        bit          known;
        bit          rdv;
    } rd_exp_t;
    rd_exp_t sbq [$];

    typedef struct {
        logic        ls;
        logic        wv;
        logic [31:0] data;
        logic [2:0]  addr;
        logic        e_ready;
        logic        e_done;
        logic        e_err;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 3'd0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive, advance the model, compare after the edge.
    task automatic step(input bit ls, input bit wv, input logic [31:0] d, input logic [2:0] a);
        rd_exp_t e;
        bit      xfer;
        load_start = ls;
        wr_valid   = wv;
        wr_data    = d;
        rd_addr    = a;
        e.data  = m_mem[a];
        e.known = m_known[a];
        e.rdv   = m_done;
        sbq.push_back(e);
        xfer = wv && (m_state == 1);
        if (m_state != 1) begin
            if (ls) begin
                m_state = 1;
                m_cnt   = 3'd0;
                m_done  = 1'b0;
                m_err   = 1'b0;
            end
        end else if (ls) begin
            m_err = 1'b1;
            if (xfer) begin
                m_mem[0]   = d;
                m_known[0] = 1'b1;
                m_cnt      = 3'd1;
            end else begin
                m_cnt = 3'd0;
            end
        end else if (xfer) begin
            m_mem[m_cnt]   = d;
            m_known[m_cnt] = 1'b1;
            if (m_cnt == 3'd7) begin
                m_state = 2;
                m_done  = 1'b1;
                m_cnt   = 3'd0;
            end else begin
                m_cnt = m_cnt + 3'd1;
            end
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        if (e.known) chk("rd_data", rd_data, e.data);
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.rdv});
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_state == 1});
        chk("load_done", {31'd0, load_done}, {31'd0, m_done});
        chk("load_err", {31'd0, load_err}, {31'd0, m_err});
        load_start = 1'b0;
        wr_valid   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"},  {31'd0, wr_ready},  32'd0);
        chk({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_load_err"},  {31'd0, load_err},  32'd0);
        chk({tag, "_rd_data"},   rd_data,            32'd0);
        chk({tag, "_rd_valid"},  {31'd0, rd_valid},  32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        bit wv;
        rst_n      = 1'b0;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 32'd0;
        rd_addr    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            m_mem[i]   = 32'd0;
            m_known[i] = 1'b0;
        end
        model_reset();

        // Basic load vectors: start, 8 back-to-back words, one idle cycle.
        tbl[0] = '{1'b1, 1'b0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 1'b1, 32'h0001_0000 * i, 3'd0, (i < 8), (i == 8), 1'b0};
        tbl[9] = '{1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Stays idle without load_start even with wr_valid high.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hFFFF_0000 + i, 3'd0);

        // Table-driven basic load.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].ls, tbl[i].wv, tbl[i].data, tbl[i].addr);
            chk($sformatf("tbl%0d_ready", i), {31'd0, wr_ready},  {31'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_done", i),  {31'd0, load_done}, {31'd0, tbl[i].e_done});
            chk($sformatf("tbl%0d_err", i),   {31'd0, load_err},  {31'd0, tbl[i].e_err});
        end

        // Sweep reads in DONE.
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b0, 32'd0, 3'(a));
            chk($sformatf("load1_entry%0d", a), rd_data, 32'h0001_0000 * (a + 1));
            chk($sformatf("load1_rdv%0d", a), {31'd0, rd_valid}, 32'd1);
        end

        // Fresh load_start: load_done falls now, rd_valid one cycle later.
        step(1'b1, 1'b0, 32'd0, 3'd0);
        chk("restart_done_low", {31'd0, load_done}, 32'd0);
        chk("restart_rdv_still", {31'd0, rd_valid}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 3'd0);
        chk("restart_rdv_low", {31'd0, rd_valid}, 32'd0);

        // Gapped producer with garbage on idle cycles.
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            wv = 1'($urandom_range(0, 1));
            step(1'b0, wv, wv ? 32'hB000_0000 + k : $urandom, 3'(k));
            if (wv) k++;
            cyc++;
        end
        chk("gap_transfers", k, 8);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 3'd0);
        chk("gap_ready_after_done", {31'd0, wr_ready}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b1, 32'hDEAD_BEEF, 3'(a));
            chk($sformatf("gap_entry%0d", a), rd_data, 32'hB000_0000 + a);
        end

        // Restart after 5 transfers; reads hit the entry being written.
        step(1'b1, 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hDEAD_0000 + i, m_cnt);
        step(1'b1, 1'b0, 32'd0, 3'd0);
        chk("restart_err_set", {31'd0, load_err}, 32'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'hAAAA_0000 + i, m_cnt);
        step(1'b0, 1'b0, 32'd0, 3'd0);
        chk("restart_err_held", {31'd0, load_err}, 32'd1);
        chk("restart_done", {31'd0, load_done}, 32'd1);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b0, 32'd0, 3'(a));
            chk($sformatf("restart_entry%0d", a), rd_data, 32'hAAAA_0000 + a);
        end

        // load_start coincident with the 3rd transfer.
        step(1'b1, 1'b0, 32'd0, 3'd0);
        chk("newload_err_clear", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h3000_0000 + i, 3'd0);
        step(1'b1, 1'b1, 32'h1234_5678, 3'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 32'h4000_0000 + i, 3'd0);
            chk($sformatf("coinc_done_after%0d", i + 1), {31'd0, load_done}, {31'd0, i == 6});
        end
        step(1'b0, 1'b0, 32'd0, 3'd0);
        chk("coinc_entry0", rd_data, 32'h1234_5678);

        // load_start coincident with the transfer at wr_cnt=7: no DONE.
        step(1'b1, 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h5000_0000 + i, 3'd0);
        step(1'b1, 1'b1, 32'h6666_0000, 3'd0);
        chk("last_coinc_no_done", {31'd0, load_done}, 32'd0);
        chk("last_coinc_ready", {31'd0, wr_ready}, 32'd1);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 32'h7000_0000 + i, 3'd0);
        chk("last_coinc_done", {31'd0, load_done}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 3'd0);
        chk("last_coinc_entry0", rd_data, 32'h6666_0000);
        step(1'b0, 1'b0, 32'd0, 3'd7);
        chk("last_coinc_entry7", rd_data, 32'h7000_0007);

        // Asynchronous reset in the middle of a load.
        step(1'b1, 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h8000_0000 + i, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_outputs("held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h9000_0000 + i, 3'd0);
        chk("post_reset_ready", {31'd0, wr_ready}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'hC000_0000 + i, 3'd0);
        for (int a = 0; a < 8; a++) begin
            step(1'b0, 1'b0, 32'd0, 3'(a));
            chk($sformatf("post_reset_entry%0d", a), rd_data, 32'hC000_0000 + a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
